// File: rtl/stream_mux_rr_pkg.sv
// Shared types for the round-robin stream multiplexer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package stream_mux_rr_pkg;

    // Arbitration FSM: IDLE picks a new grant each cycle, LOCKED holds it until last.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage : stream_mux_rr_pkg

// File: rtl/rr_pick.sv
// Wrap-around priority scan: first requester at or after ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its own load condition.
module rr_pick #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                gnt_any
);

    // Scan CHANNELS slots starting at ptr; modulo done by a single subtract
    // since ptr is always below CHANNELS.
    always_comb begin
        int         idx;
        logic [SEL_W-1:0] lidx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        lidx    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            lidx = SEL_W'(idx);
            if (!gnt_any && req[lidx]) begin
                gnt_any = 1'b1;
                gnt_idx = lidx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/stream_mux_rr.sv
// N:1 registered stream mux with round-robin arbitration, packet lock and forced select.
// Latency: 1 cycle from input accept to out_valid.
// Backpressure: output register loads when empty or drained; otherwise every in_ready is 0.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SEL_W:0]   NUM_CH = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             lock_forced_q, lock_forced_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic             pkt_forced;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             sel_valid;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign load = !out_valid_q || out_ready;

    // Grant source: held lock, forced channel (range-checked), or round-robin scan.
    always_comb begin
        grant      = '0;
        grant_ok   = 1'b0;
        pkt_forced = 1'b0;
        if (state_q == ST_LOCKED) begin
            grant      = lock_ch_q;
            grant_ok   = 1'b1;
            pkt_forced = lock_forced_q;
        end else if (force_en) begin
            grant      = force_sel;
            grant_ok   = ({1'b0, force_sel} < NUM_CH);
            pkt_forced = 1'b1;
        end else begin
            grant      = pick_idx;
            grant_ok   = pick_any;
        end
    end

    // Select the granted channel's beat; only in-range indices can match.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant == SEL_W'(c)) begin
                sel_data  = in_data[c*WIDTH +: WIDTH];
                sel_last  = in_last[c];
                sel_valid = in_valid[c];
            end
        end
    end

    assign accept = load && grant_ok && sel_valid;

    // One-hot ready toward the granted channel; forced low while in reset.
    always_comb begin
        in_ready = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            in_ready[c] = reset_n && accept && (grant == SEL_W'(c));
        end
    end

    // Packet FSM, rr pointer and lock bookkeeping; forced packets leave ptr alone.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        lock_ch_d     = lock_ch_q;
        lock_forced_d = lock_forced_q;
        if (accept) begin
            if (sel_last) begin
                state_d = ST_IDLE;
                if (!pkt_forced) begin
                    ptr_d = (grant == LAST_CH) ? '0 : grant + 1'b1;
                end
            end else if (state_q == ST_IDLE) begin
                state_d       = ST_LOCKED;
                lock_ch_d     = grant;
                lock_forced_d = pkt_forced;
            end
        end
    end

    // Output register: capture on accept, drop valid on an empty load, else hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = sel_data;
                out_last_d = sel_last;
                out_sel_d  = grant;
            end
        end
    end

    // State and output flops; reset aborts any partial packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            lock_ch_q     <= '0;
            lock_forced_q <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_sel_q     <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            lock_ch_q     <= lock_ch_d;
            lock_forced_q <= lock_forced_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_sel_q     <= out_sel_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule : stream_mux_rr

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel and a 3-channel instance.
// Latency: n/a.
// Backpressure: driven directly through out_ready.
module tb_stream_mux_rr;

    logic clk;
    logic reset_n;

    // 4-channel instance
    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_last, a_in_ready;
    logic        a_force_en;
    logic [1:0]  a_force_sel;
    logic [7:0]  a_out_data;
    logic        a_out_last, a_out_valid, a_out_ready;
    logic [1:0]  a_out_sel;

    // 3-channel instance
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid, b_in_last, b_in_ready;
    logic        b_force_en;
    logic [1:0]  b_force_sel;
    logic [7:0]  b_out_data;
    logic        b_out_last, b_out_valid, b_out_ready;
    logic [1:0]  b_out_sel;

    int checks   = 0;
    int failures = 0;

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_last   (a_in_last),
        .in_ready  (a_in_ready),
        .force_en  (a_force_en),
        .force_sel (a_force_sel),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .out_sel   (a_out_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .CHANNELS(3)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_last   (b_in_last),
        .in_ready  (b_in_ready),
        .force_en  (b_force_en),
        .force_sel (b_force_sel),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .out_sel   (b_out_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic a_set(input int ch, input logic [7:0] val);
        a_in_data[ch*8 +: 8] = val;
    endtask

    task automatic b_set(input int ch, input logic [7:0] val);
        b_in_data[ch*8 +: 8] = val;
    endtask

    task automatic a_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] s, input logic l);
        chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
        chk({tag, ".data"},  32'(a_out_data),  32'(d));
        chk({tag, ".sel"},   32'(a_out_sel),   32'(s));
        chk({tag, ".last"},  32'(a_out_last),  32'(l));
    endtask

    initial begin
        reset_n     = 1'b0;
        a_in_data   = '0; a_in_valid = 4'hF; a_in_last = '0;
        a_force_en  = 1'b0; a_force_sel = '0; a_out_ready = 1'b1;
        b_in_data   = '0; b_in_valid = '0; b_in_last = '0;
        b_force_en  = 1'b0; b_force_sel = '0; b_out_ready = 1'b1;

        // Reset state with requests pending
        #3;
        a_out("rst", 1'b0, 8'h00, 2'd0, 1'b0);
        chk("rst.in_ready", 32'(a_in_ready), 32'h0);
        step();
        reset_n = 1'b1;

        // Round-robin over single-beat packets: 0,1,2,3,0
        for (int c = 0; c < 4; c++) a_set(c, 8'(8'h10 + c));
        a_in_valid = 4'hF; a_in_last = 4'hF;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("rr%0d.in_ready", k), 32'(a_in_ready), 32'(1 << (k % 4)));
            if (k == 0) chk("rr0.valid", 32'(a_out_valid), 32'h0);
            else a_out($sformatf("rr%0d", k), 1'b1, 8'(8'h10 + (k - 1) % 4), 2'((k - 1) % 4), 1'b1);
            step();
        end
        a_in_valid = 4'h0;
        settle();
        a_out("rr5", 1'b1, 8'h10, 2'd0, 1'b1);
        step();
        settle();
        chk("rr6.valid", 32'(a_out_valid), 32'h0);

        // Packet lock on channel 2 (ptr=1) with a 2-cycle valid gap
        a_set(2, 8'h20); a_set(0, 8'h30); a_in_last = 4'b0011; a_in_valid = 4'b0100;
        settle(); chk("lk0.in_ready", 32'(a_in_ready), 32'b0100);
        step();
        a_set(2, 8'h21); a_in_valid = 4'b0111;
        settle(); chk("lk1.in_ready", 32'(a_in_ready), 32'b0100);
        a_out("lk1", 1'b1, 8'h20, 2'd2, 1'b0);
        step();
        a_in_valid = 4'b0011;
        settle(); chk("lk2.in_ready", 32'(a_in_ready), 32'h0);
        a_out("lk2", 1'b1, 8'h21, 2'd2, 1'b0);
        step();
        settle(); chk("lk3.in_ready", 32'(a_in_ready), 32'h0);
        chk("lk3.valid", 32'(a_out_valid), 32'h0);
        step();
        a_set(2, 8'h22); a_in_last = 4'b0111; a_in_valid = 4'b0111;
        settle(); chk("lk4.in_ready", 32'(a_in_ready), 32'b0100);
        chk("lk4.valid", 32'(a_out_valid), 32'h0);
        step();
        a_in_last = 4'b0011; a_in_valid = 4'b0011;
        settle(); chk("lk5.in_ready", 32'(a_in_ready), 32'b0001);
        a_out("lk5", 1'b1, 8'h22, 2'd2, 1'b1);
        step();
        a_in_valid = 4'h0;
        settle(); a_out("lk6", 1'b1, 8'h30, 2'd0, 1'b1);
        step();

        // Backpressure: hold 0xA5 for 5 cycles (ptr=1)
        a_set(1, 8'hA5); a_set(3, 8'h3C); a_in_last = 4'hF; a_in_valid = 4'b1010;
        settle(); chk("bp0.in_ready", 32'(a_in_ready), 32'b0010);
        step();
        a_out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            settle();
            chk($sformatf("bp%0d.in_ready", k), 32'(a_in_ready), 32'h0);
            a_out($sformatf("bp%0d", k), 1'b1, 8'hA5, 2'd1, 1'b1);
            step();
        end
        a_out_ready = 1'b1;
        settle(); chk("bp6.in_ready", 32'(a_in_ready), 32'b1000);
        a_out("bp6", 1'b1, 8'hA5, 2'd1, 1'b1);
        step();
        settle(); chk("bp7.in_ready", 32'(a_in_ready), 32'b0010);
        a_out("bp7", 1'b1, 8'h3C, 2'd3, 1'b1);
        step();
        a_in_valid = 4'h0;
        settle(); a_out("bp8", 1'b1, 8'hA5, 2'd1, 1'b1);
        step();
        settle(); chk("bp9.valid", 32'(a_out_valid), 32'h0);

        // Forced select on channel 1 (ptr=2 must survive)
        for (int c = 0; c < 4; c++) a_set(c, 8'(8'h40 + c));
        a_force_en = 1'b1; a_force_sel = 2'd1; a_in_valid = 4'hF; a_in_last = 4'hF;
        settle(); chk("fc0.in_ready", 32'(a_in_ready), 32'b0010);
        step();
        settle(); chk("fc1.in_ready", 32'(a_in_ready), 32'b0010);
        a_out("fc1", 1'b1, 8'h41, 2'd1, 1'b1);
        step();
        a_force_en = 1'b0;
        settle(); chk("fc2.in_ready", 32'(a_in_ready), 32'b0100);
        step();
        // Round-robin packet on channel 3, then force asserted mid-packet
        a_set(3, 8'h50); a_in_last = 4'b0111; a_in_valid = 4'b1000;
        settle(); chk("fc3.in_ready", 32'(a_in_ready), 32'b1000);
        a_out("fc3", 1'b1, 8'h42, 2'd2, 1'b1);
        step();
        a_set(3, 8'h51); a_force_en = 1'b1; a_in_valid = 4'hF;
        settle(); chk("fc4.in_ready", 32'(a_in_ready), 32'b1000);
        a_out("fc4", 1'b1, 8'h50, 2'd3, 1'b0);
        step();
        a_set(3, 8'h52); a_in_last = 4'hF;
        settle(); chk("fc5.in_ready", 32'(a_in_ready), 32'b1000);
        step();
        settle(); chk("fc6.in_ready", 32'(a_in_ready), 32'b0010);
        a_out("fc6", 1'b1, 8'h52, 2'd3, 1'b1);
        step();
        a_force_en = 1'b0;
        settle(); chk("fc7.in_ready", 32'(a_in_ready), 32'b0001);
        a_out("fc7", 1'b1, 8'h41, 2'd1, 1'b1);
        step();
        a_in_valid = 4'h0;
        settle(); a_out("fc8", 1'b1, 8'h40, 2'd0, 1'b1);
        step();

        // Reset in the middle of a locked packet on channel 0 (ptr=1)
        a_set(0, 8'h70); a_in_last = 4'h0; a_in_valid = 4'b0001;
        settle(); chk("rs0.in_ready", 32'(a_in_ready), 32'b0001);
        step();
        a_in_valid = 4'b0011;
        settle(); a_out("rs1", 1'b1, 8'h70, 2'd0, 1'b0);
        chk("rs1.in_ready", 32'(a_in_ready), 32'b0001);
        reset_n = 1'b0;
        settle(); a_out("rs1.async", 1'b0, 8'h00, 2'd0, 1'b0);
        chk("rs1.async.in_ready", 32'(a_in_ready), 32'h0);
        step();
        reset_n = 1'b1; a_in_last = 4'hF; a_in_valid = 4'b0010;
        settle(); chk("rs2.unlocked", 32'(a_in_ready), 32'b0010);
        a_in_valid = 4'hF;
        settle(); chk("rs2.ptr0", 32'(a_in_ready), 32'b0001);
        step();
        a_in_valid = 4'h0;
        settle(); a_out("rs3", 1'b1, 8'h70, 2'd0, 1'b1);
        step();

        // Three channels: wrap from ptr=2 and out-of-range force
        b_set(0, 8'h60); b_set(1, 8'h61); b_set(2, 8'h62); b_in_last = 3'b111;
        b_in_valid = 3'b010;
        settle(); chk("w0.in_ready", 32'(b_in_ready), 32'b010);
        step();
        b_in_valid = 3'b001;
        settle(); chk("w1.in_ready", 32'(b_in_ready), 32'b001);
        chk("w1.sel", 32'(b_out_sel), 32'd1);
        chk("w1.data", 32'(b_out_data), 32'h61);
        step();
        b_in_valid = 3'b111;
        settle(); chk("w2.in_ready", 32'(b_in_ready), 32'b010);
        chk("w2.sel", 32'(b_out_sel), 32'd0);
        chk("w2.data", 32'(b_out_data), 32'h60);
        step();
        b_force_en = 1'b1; b_force_sel = 2'd3;
        settle(); chk("w3.in_ready", 32'(b_in_ready), 32'b000);
        chk("w3.sel", 32'(b_out_sel), 32'd1);
        step();
        settle(); chk("w4.valid", 32'(b_out_valid), 32'h0);
        b_force_sel = 2'd2;
        settle(); chk("w4.in_ready", 32'(b_in_ready), 32'b100);
        step();
        b_in_valid = 3'b000; b_force_en = 1'b0;
        settle(); chk("w5.sel", 32'(b_out_sel), 32'd2);
        chk("w5.data", 32'(b_out_data), 32'h62);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stream_mux_rr
